// File: rtl/order_tx_encoder.sv
// order_tx_encoder
// Buffers single-cycle trade decisions in a small FIFO and serialises each one
// into a fixed 10-byte outbound order message on a valid/ready byte stream:
//   byte 0     : 0xA5 start marker
//   byte 1     : message sequence number (8-bit, wrapping)
//   bytes 2-3  : product, MSB first
//   bytes 4-7  : price, MSB first
//   byte 8     : 0x01 buy / 0x00 sell
//   byte 9     : XOR of bytes 0..8
// A minimum number of idle cycles is enforced after each message, and trades
// arriving while the FIFO is full are counted in a saturating drop counter.

module order_tx_encoder #(
    parameter int FIFO_DEPTH = 4,   // pending trades buffered (power of two, >= 2)
    parameter int MIN_GAP    = 4    // idle cycles after each message (0 = back-to-back)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trade,
    input  logic [15:0] trade_product,
    input  logic [31:0] trade_price,
    input  logic        trade_buy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic [15:0] drop_count,
    output logic        busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int ENTRY_W = 16 + 32 + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD   = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;
    localparam logic [3:0]       LAST_IDX   = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Trade FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               drop;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // ------------------------------------------------------------------
    // Message serialiser state
    // ------------------------------------------------------------------
    state_t             state;
    logic [7:0]         seq;
    logic [GAP_W-1:0]   gap_cnt;
    logic [3:0]         byte_idx;
    logic [71:0]        rest_q;     // bytes still to be presented after tx_data, MSB = next
    logic [79:0]        load_msg;

    // Full is judged on the count at the start of the cycle, so a trade that
    // arrives while full is dropped even if the head is popped in that cycle.
    assign push = trade && (count != FULL_COUNT);
    assign drop = trade && (count == FULL_COUNT);
    assign head = fifo_mem[rd_ptr];

    assign busy = (count != '0) || (state != IDLE);

    // Build the complete 10-byte message, checksum included, from one trade.
    function automatic logic [79:0] build_msg(
        input logic [7:0]  s,
        input logic [15:0] product,
        input logic [31:0] price,
        input logic        buy
    );
        logic [71:0] body;
        logic [7:0]  csum;
        body = {8'hA5, s, product, price, 7'd0, buy};
        csum = '0;
        for (int i = 0; i < 9; i++) begin
            csum = csum ^ body[8*i +: 8];
        end
        return {body, csum};
    endfunction

    // Decide whether the head trade is taken this cycle. The last GAP cycle
    // doubles as the IDLE decision cycle so that the line sees exactly MIN_GAP
    // idle cycles between messages; with MIN_GAP = 0 the next message is
    // loaded on the same edge that the previous last byte is accepted.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the case statement leaves it unassigned
        // and no latch is inferred.
        pop = 1'b0;
        if (count != '0) begin
            case (state)
                IDLE:    pop = 1'b1;
                GAP:     pop = (gap_cnt == '0);
                SEND:    pop = (MIN_GAP == 0) && tx_ready && (byte_idx == LAST_IDX);
                default: pop = 1'b0;
            endcase
        end
    end

    // Message image for the head trade, stamped with the current sequence number.
    always_comb begin
        load_msg = build_msg(seq, head[48:33], head[32:1], head[0]);
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // after it has been written, because count guards every pop.
        if (push) begin
            fifo_mem[wr_ptr] <= {trade_product, trade_price, trade_buy};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of trades lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Serialiser FSM with registered stream outputs. tx_data/sop/eop change
    // only on an accepted byte or a new load, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            seq      <= '0;
            gap_cnt  <= '0;
            byte_idx <= '0;
            rest_q   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
        end else if (pop) begin
            // Start a new message: present byte 0, keep bytes 1..9 queued.
            state    <= SEND;
            seq      <= seq + 8'd1;
            byte_idx <= '0;
            rest_q   <= load_msg[71:0];
            tx_data  <= load_msg[79:72];
            tx_valid <= 1'b1;
            tx_sop   <= 1'b1;
            tx_eop   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_valid <= 1'b0;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            tx_eop   <= 1'b0;
                            tx_data  <= '0;
                            gap_cnt  <= GAP_LOAD;
                            state    <= (MIN_GAP > 0) ? GAP : IDLE;
                        end else begin
                            tx_data  <= rest_q[71:64];
                            rest_q   <= {rest_q[63:0], 8'h00};
                            byte_idx <= byte_idx + 4'd1;
                            tx_sop   <= 1'b0;
                            tx_eop   <= (byte_idx == LAST_IDX - 4'd1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_order_tx_encoder.sv
// tb_order_tx_encoder
// Self-checking bench for order_tx_encoder. A per-cycle collector rebuilds
// messages from the byte stream; each test task compares them against
// messages built from the trade fields by the reference model below.

module tb_order_tx_encoder;

    localparam int FIFO_DEPTH = 4;
    localparam int MIN_GAP    = 4;
    localparam int WRAP_MSGS  = 257;

    logic        clk = 1'b0;
    logic        rst;
    logic        trade;
    logic [15:0] trade_product;
    logic [31:0] trade_price;
    logic        trade_buy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_ready;
    logic [15:0] drop_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Collector state
    logic [79:0] rx_q [$];
    int          gap_q [$];
    logic [79:0] col_msg;
    int          cyc;
    int          col_idx;
    int          col_gap;
    int          sop_cyc;
    int          eop_cyc;
    int          stall_err;
    int          frame_err;
    logic        stall_hold;
    logic [7:0]  hold_data;
    logic        hold_sop;
    logic        hold_eop;

    always #5 clk = ~clk;

    order_tx_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trade         (trade),
        .trade_product (trade_product),
        .trade_price   (trade_price),
        .trade_buy     (trade_buy),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_sop        (tx_sop),
        .tx_eop        (tx_eop),
        .tx_ready      (tx_ready),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    // Reference model: the outbound message as a list of bytes, packed MSB first.
    function automatic logic [79:0] model_msg(input int seq, input logic [15:0] product,
                                              input logic [31:0] price, input logic buy);
        logic [7:0]  b [10];
        logic [79:0] m;
        b[0] = 8'hA5;
        b[1] = 8'(seq % 256);
        b[2] = product[15:8];
        b[3] = product[7:0];
        b[4] = price[31:24];
        b[5] = price[23:16];
        b[6] = price[15:8];
        b[7] = price[7:0];
        b[8] = buy ? 8'h01 : 8'h00;
        b[9] = 8'h00;
        for (int i = 0; i < 9; i++) b[9] = b[9] ^ b[i];
        m = '0;
        for (int i = 0; i < 10; i++) m = {m[71:0], b[i]};
        return m;
    endfunction

    task automatic col_reset();
        rx_q.delete();
        gap_q.delete();
        col_msg    = '0;
        col_idx    = 0;
        col_gap    = 0;
        sop_cyc    = -1;
        eop_cyc    = -1;
        stall_err  = 0;
        frame_err  = 0;
        stall_hold = 1'b0;
    endtask

    // Observe one cycle of the stream (called mid-cycle, away from the edge).
    task automatic sample_cycle();
        cyc++;
        if (tx_valid === 1'b1) begin
            if (stall_hold && (tx_data !== hold_data || tx_sop !== hold_sop || tx_eop !== hold_eop))
                stall_err++;
            if (tx_ready) begin
                if ((col_idx == 0) != (tx_sop === 1'b1)) frame_err++;
                if ((col_idx == 9) != (tx_eop === 1'b1)) frame_err++;
                if (col_idx == 0) begin
                    gap_q.push_back(col_gap);
                    sop_cyc = cyc;
                end
                col_msg = {col_msg[71:0], tx_data};
                col_idx++;
                if (col_idx == 10) begin
                    rx_q.push_back(col_msg);
                    col_idx = 0;
                    col_gap = 0;
                    eop_cyc = cyc;
                end
                stall_hold = 1'b0;
            end else begin
                stall_hold = 1'b1;
                hold_data  = tx_data;
                hold_sop   = tx_sop;
                hold_eop   = tx_eop;
            end
        end else begin
            if (col_idx != 0 || stall_hold) frame_err++;
            col_gap++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        trade         = 1'b0;
        trade_product = '0;
        trade_price   = '0;
        trade_buy     = 1'b0;
        tx_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        col_reset();
    endtask

    task automatic push_trade(input logic [15:0] p, input logic [31:0] pr, input logic b);
        trade         = 1'b1;
        trade_product = p;
        trade_price   = pr;
        trade_buy     = b;
        tick();
        trade = 1'b0;
    endtask

    task automatic wait_msgs(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        timed_out = (rx_q.size() < n);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_sop !== 1'b0) begin errors++; $display("FAIL reset_tx_sop: got %b want 0", tx_sop); end
        checks++; if (tx_eop !== 1'b0) begin errors++; $display("FAIL reset_tx_eop: got %b want 0", tx_eop); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    endtask

    task automatic test_single();
        bit          to;
        int          n;
        logic [15:0] p2;
        logic [31:0] pr2;
        logic        b2;
        logic [79:0] m;
        do_reset();
        tx_ready = 1'b1;
        n = cyc + 1;
        push_trade(16'h1234, 32'h0000_03E8, 1'b1);
        wait_msgs(1, 40, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got %0d msgs want 1", rx_q.size()); end
        if (!to) begin
            checks++; if (rx_q[0] !== 80'hA5_00_12_34_00_00_03_E8_01_69) begin errors++; $display("FAIL single_bytes: got %h want a5001234000003e80169", rx_q[0]); end
            checks++; if (sop_cyc != n + 2) begin errors++; $display("FAIL single_sop_latency: got cycle %0d want %0d", sop_cyc, n + 2); end
            checks++; if (eop_cyc != n + 11) begin errors++; $display("FAIL single_eop_latency: got cycle %0d want %0d", eop_cyc, n + 11); end
        end
        p2  = 16'($urandom);
        pr2 = $urandom;
        b2  = 1'($urandom_range(0, 1));
        push_trade(p2, pr2, b2);
        wait_msgs(2, 60, to);
        checks++; if (to) begin errors++; $display("FAIL single_second_timeout: got %0d msgs want 2", rx_q.size()); end
        if (!to) begin
            m = rx_q[1];
            checks++; if (m !== model_msg(1, p2, pr2, b2)) begin errors++; $display("FAIL single_second_msg: got %h want %h", m, model_msg(1, p2, pr2, b2)); end
            checks++; if (m[71:64] !== 8'h01) begin errors++; $display("FAIL single_second_seq: got %h want 01", m[71:64]); end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL single_framing: got %0d errors want 0", frame_err); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        do_reset();
        tx_ready = 1'b1;
        push_trade(16'h1234, 32'h0000_03E8, 1'b1);
        while (rx_q.size() < 1 && k < 200) begin
            tx_ready = (k % 3 == 0);
            tick();
            k++;
        end
        checks++; if (rx_q.size() < 1) begin errors++; $display("FAIL bp_timeout: got %0d msgs want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 80'hA5_00_12_34_00_00_03_E8_01_69) begin errors++; $display("FAIL bp_bytes: got %h want a5001234000003e80169", rx_q[0]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes under stall want 0", stall_err); end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL bp_framing: got %0d errors want 0", frame_err); end
        repeat (20) tick();
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL bp_extra_msgs: got %0d msgs want 1", rx_q.size()); end
    endtask

    task automatic test_overflow();
        logic [79:0] exp_q [$];
        logic [15:0] p;
        logic [31:0] pr;
        logic        b;
        bit          to;
        int          k = 0;
        do_reset();
        tx_ready = 1'b0;
        p  = 16'($urandom);
        pr = $urandom;
        b  = 1'($urandom_range(0, 1));
        exp_q.push_back(model_msg(0, p, pr, b));
        push_trade(p, pr, b);
        while (tx_valid !== 1'b1 && k < 10) begin tick(); k++; end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL ovf_first_valid: got %b want 1", tx_valid); end
        // With the first message stalled on the line, the FIFO is empty and
        // takes exactly FIFO_DEPTH of the six trades that follow.
        for (int i = 0; i < 6; i++) begin
            p  = 16'($urandom);
            pr = $urandom;
            b  = 1'($urandom_range(0, 1));
            if (i < FIFO_DEPTH) exp_q.push_back(model_msg(i + 1, p, pr, b));
            push_trade(p, pr, b);
        end
        tick();
        checks++; if (drop_count !== 16'(6 - FIFO_DEPTH)) begin errors++; $display("FAIL ovf_drop_count: got %0d want %0d", drop_count, 6 - FIFO_DEPTH); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b want 1", busy); end
        tx_ready = 1'b1;
        wait_msgs(exp_q.size(), 400, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got %0d msgs want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_msg%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        repeat (30) tick();
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_msg_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_after: got %b want 0", busy); end
    endtask

    // Runs straight after the overflow test so drop_count and seq are non-zero.
    task automatic test_reset_mid();
        logic [15:0] p;
        logic [31:0] pr;
        logic        b;
        bit          to;
        int          k = 0;
        col_reset();
        tx_ready = 1'b1;
        push_trade(16'($urandom), $urandom, 1'($urandom_range(0, 1)));
        while (col_idx != 5 && k < 40) begin tick(); k++; end
        checks++; if (col_idx != 5) begin errors++; $display("FAIL rmid_reach_byte5: got index %0d want 5", col_idx); end
        tx_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_eop !== 1'b0) begin errors++; $display("FAIL rmid_tx_eop: got %b want 0", tx_eop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rmid_drop_count: got %0d want 0", drop_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        col_reset();
        tx_ready = 1'b1;
        p  = 16'($urandom);
        pr = $urandom;
        b  = 1'($urandom_range(0, 1));
        push_trade(p, pr, b);
        wait_msgs(1, 40, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout: got %0d msgs want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== model_msg(0, p, pr, b)) begin errors++; $display("FAIL rmid_new_msg: got %h want %h", rx_q[0], model_msg(0, p, pr, b)); end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL rmid_framing: got %0d errors want 0", frame_err); end
    endtask

    task automatic test_gap();
        logic [79:0] exp_q [$];
        logic [15:0] p;
        logic [31:0] pr;
        logic        b;
        bit          to;
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p  = 16'($urandom);
            pr = $urandom;
            b  = 1'($urandom_range(0, 1));
            exp_q.push_back(model_msg(i, p, pr, b));
            push_trade(p, pr, b);
        end
        wait_msgs(2, 60, to);
        checks++; if (to) begin errors++; $display("FAIL gap_timeout: got %0d msgs want 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== exp_q[0]) begin errors++; $display("FAIL gap_msg0: got %h want %h", rx_q[0], exp_q[0]); end
            checks++; if (rx_q[1] !== exp_q[1]) begin errors++; $display("FAIL gap_msg1: got %h want %h", rx_q[1], exp_q[1]); end
            checks++; if (gap_q.size() < 2 || gap_q[1] != MIN_GAP) begin errors++; $display("FAIL gap_length: got %0d idle cycles want %0d", (gap_q.size() < 2) ? -1 : gap_q[1], MIN_GAP); end
        end
    endtask

    task automatic test_seq_wrap();
        logic [79:0] exp_q [$];
        logic [15:0] p;
        logic [31:0] pr;
        logic        b;
        int          sent = 0;
        int          guard = 0;
        int          bad_gap = 0;
        int          bad_msg = 0;
        do_reset();
        // Random issue and random backpressure; a new trade is only offered
        // while fewer than FIFO_DEPTH are outstanding, so none may be dropped.
        while (rx_q.size() < WRAP_MSGS && guard < 60000) begin
            if (sent < WRAP_MSGS && (sent - rx_q.size()) < FIFO_DEPTH && $urandom_range(0, 2) == 0) begin
                p  = 16'($urandom);
                pr = $urandom;
                b  = 1'($urandom_range(0, 1));
                exp_q.push_back(model_msg(sent, p, pr, b));
                sent++;
                trade         = 1'b1;
                trade_product = p;
                trade_price   = pr;
                trade_buy     = b;
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
            trade = 1'b0;
            guard++;
        end
        checks++; if (rx_q.size() != WRAP_MSGS) begin errors++; $display("FAIL wrap_timeout: got %0d msgs want %0d", rx_q.size(), WRAP_MSGS); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                bad_msg++;
                if (bad_msg <= 8) $display("FAIL wrap_msg%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        if (rx_q.size() == WRAP_MSGS) begin
            checks++; if (rx_q[255][71:64] !== 8'hFF) begin errors++; $display("FAIL wrap_seq_ff: got %h want ff", rx_q[255][71:64]); end
            checks++; if (rx_q[256][71:64] !== 8'h00) begin errors++; $display("FAIL wrap_seq_00: got %h want 00", rx_q[256][71:64]); end
        end
        for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] < MIN_GAP) bad_gap++;
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL wrap_min_gap: got %0d short gaps want 0", bad_gap); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL wrap_stable: got %0d changes under stall want 0", stall_err); end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL wrap_framing: got %0d errors want 0", frame_err); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL wrap_drop_count: got %0d want 0", drop_count); end
    endtask

    initial begin
        cyc = 0;
        col_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_gap();
        test_seq_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
